// File: rtl/intersection_scheduler.sv
// Two-way intersection sequencer: arbitrates NS/EW greens and a pedestrian walk
// phase from latched calls, with min/max green, yellow and all-red clearance.
module intersection_scheduler #(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 5,
  parameter int TW        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car_ns,
  input  logic       car_ew,
  input  logic       ped_req,
  output logic [1:0] ns_color,
  output logic [1:0] ew_color,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_AR_NS = 3'd0,
    S_NS_G  = 3'd1,
    S_NS_Y  = 3'd2,
    S_AR_EW = 3'd3,
    S_EW_G  = 3'd4,
    S_EW_Y  = 3'd5,
    S_WALK  = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    C_RED = 2'b00,
    C_YEL = 2'b01,
    C_GRN = 2'b10
  } color_e;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_e;

  // Terminal timer values: a phase of length N ends when the timer reads N-1.
  localparam logic [TW-1:0] ALLRED_END = TW'(ALLRED_T - 1);
  localparam logic [TW-1:0] YELLOW_END = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] WALK_END   = TW'(WALK_T - 1);
  localparam logic [TW-1:0] GMIN_END   = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] GMAX_END   = TW'(GREEN_MAX - 1);
  localparam logic [TW-1:0] TIMER_SAT  = '1;

  state_e        state;
  state_e        next_state;
  logic [TW-1:0] timer;
  logic          call_ns;
  logic          call_ew;
  logic          ped_pend;
  dir_e          last_dir;
  logic          entering;

  function automatic color_e head_color(state_e s, state_e green_s, state_e yellow_s);
    if (s == green_s)       return C_GRN;
    else if (s == yellow_s) return C_YEL;
    else                    return C_RED;
  endfunction

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      S_AR_NS: if (timer == ALLRED_END) next_state = S_NS_G;
      S_NS_G: begin
        if (timer >= GMIN_END && (call_ew || ped_pend) &&
            (!car_ns || timer >= GMAX_END))
          next_state = S_NS_Y;
      end
      S_NS_Y:  if (timer == YELLOW_END) next_state = ped_pend ? S_WALK : S_AR_EW;
      S_AR_EW: if (timer == ALLRED_END) next_state = S_EW_G;
      S_EW_G: begin
        if (timer >= GMIN_END && (call_ns || ped_pend) &&
            (!car_ew || timer >= GMAX_END))
          next_state = S_EW_Y;
      end
      S_EW_Y:  if (timer == YELLOW_END) next_state = ped_pend ? S_WALK : S_AR_NS;
      S_WALK: begin
        // Serve the direction that did not just clear through yellow.
        if (timer == WALK_END) next_state = (last_dir == DIR_NS) ? S_AR_EW : S_AR_NS;
      end
      default: next_state = S_AR_NS;
    endcase
  end

  assign entering = (next_state != state);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_AR_NS;
      timer    <= '0;
      call_ns  <= 1'b0;
      call_ew  <= 1'b0;
      ped_pend <= 1'b0;
      last_dir <= DIR_EW;
      ns_color <= C_RED;
      ew_color <= C_RED;
      walk     <= 1'b0;
      ped_ack  <= 1'b0;
      phase    <= S_AR_NS;
    end else begin
      state <= next_state;

      if (entering)                timer <= '0;
      else if (timer != TIMER_SAT) timer <= timer + TW'(1);

      // Entry into the served green wins over a same-cycle detector hit.
      if (entering && next_state == S_NS_G)  call_ns <= 1'b0;
      else if (car_ns && state != S_NS_G)    call_ns <= 1'b1;

      if (entering && next_state == S_EW_G)  call_ew <= 1'b0;
      else if (car_ew && state != S_EW_G)    call_ew <= 1'b1;

      if (entering && next_state == S_WALK)  ped_pend <= 1'b0;
      else if (ped_req)                      ped_pend <= 1'b1;

      if (entering && state == S_NS_Y)       last_dir <= DIR_NS;
      else if (entering && state == S_EW_Y)  last_dir <= DIR_EW;

      // Outputs are registered decodes of the state being entered.
      ns_color <= head_color(next_state, S_NS_G, S_NS_Y);
      ew_color <= head_color(next_state, S_EW_G, S_EW_Y);
      walk     <= (next_state == S_WALK);
      ped_ack  <= entering && (next_state == S_WALK);
      phase    <= next_state;
    end
  end

  a_no_conflict: assert property (@(posedge clk) disable iff (reset)
    !(ns_color != C_RED && ew_color != C_RED));

  a_walk_all_red: assert property (@(posedge clk) disable iff (reset)
    !(walk && (ns_color != C_RED || ew_color != C_RED)));

endmodule
